// File: rtl/gf_serial_mul_pow.sv
// gf_serial_mul_pow: bit-serial GF(2^W) multiply and constant-time power engine.
module gf_serial_mul_pow #(
  parameter int W = 8,
  parameter logic [W-1:0] POLY = 8'h63,
  parameter int EW = 8
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic          mode,
  input  logic [W-1:0]  a,
  input  logic [W-1:0]  b,
  input  logic [EW-1:0] e,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [W-1:0]  p
);
  localparam int CW = $clog2(W + 1);
  localparam int KW = $clog2(EW + 1);
  typedef enum logic [1:0] {IDLE, MUL, POW, DONE} state_t;
  state_t state, state_n;
  logic [W-1:0] acc1, x1, m1, acc2, x2, m2, r, s;
  logic [W-1:0] acc1_n, x1_n, m1_n, acc2_n, x2_n, m2_n, r_n;
  logic [EW-1:0] q;
  logic [CW-1:0] cnt;
  logic [KW-1:0] k;
  logic mul_end, pow_end, round_end;
  assign in_ready = state == IDLE;
  assign out_valid = state == DONE;
  assign mul_end = cnt == CW'(W);
  assign pow_end = k == KW'(EW);
  assign round_end = cnt == CW'(W - 1);
  // Two serial multipliers: #1 does a*b (MUL) or r*s (POW), #2 does s*s.
  always_comb begin
    acc1_n = acc1 ^ (m1[0] ? x1 : '0);
    x1_n = {x1[W-2:0], 1'b0} ^ (x1[W-1] ? POLY : '0);
    m1_n = m1 >> 1;
    acc2_n = acc2 ^ (m2[0] ? x2 : '0);
    x2_n = {x2[W-2:0], 1'b0} ^ (x2[W-1] ? POLY : '0);
    m2_n = m2 >> 1;
    r_n = q[0] ? acc1_n : r;
  end
  always_comb begin
    state_n = state;
    unique case (state)
      IDLE: if (in_valid) state_n = mode ? POW : MUL;
      MUL: if (mul_end) state_n = DONE;
      POW: if (pow_end) state_n = DONE;
      DONE: if (out_ready) state_n = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= IDLE;
    else state <= state_n;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc1 <= '0;
      x1 <= '0;
      m1 <= '0;
      acc2 <= '0;
      x2 <= '0;
      m2 <= '0;
      r <= '0;
      s <= '0;
      q <= '0;
      cnt <= '0;
      k <= '0;
      p <= '0;
    end else begin
      unique case (state)
        IDLE: if (in_valid) begin
          acc1 <= '0;
          acc2 <= '0;
          x1 <= mode ? W'(1) : a;
          m1 <= mode ? a : b;
          x2 <= a;
          m2 <= a;
          r <= W'(1);
          s <= a;
          q <= e;
          cnt <= '0;
          k <= '0;
        end
        MUL: if (mul_end) p <= acc1;
        else begin
          acc1 <= acc1_n;
          x1 <= x1_n;
          m1 <= m1_n;
          cnt <= cnt + CW'(1);
        end
        POW: if (pow_end) p <= r;
        else if (round_end) begin
          // Close the round and preload both multipliers with the new r and s.
          r <= r_n;
          s <= acc2_n;
          q <= q >> 1;
          k <= k + KW'(1);
          cnt <= '0;
          acc1 <= '0;
          acc2 <= '0;
          x1 <= r_n;
          m1 <= acc2_n;
          x2 <= acc2_n;
          m2 <= acc2_n;
        end else begin
          acc1 <= acc1_n;
          x1 <= x1_n;
          m1 <= m1_n;
          acc2 <= acc2_n;
          x2 <= x2_n;
          m2 <= m2_n;
          cnt <= cnt + CW'(1);
        end
        DONE: ;
      endcase
    end
  end
endmodule
